// File: rtl/spi_st_master_pkg.sv
// spi_st_master_pkg: shared types and constants for the SPI stream master.
// Holds the FSM state enum, byte width and default timing values.
package spi_st_master_pkg;

  localparam int SPI_BYTE_BITS = 8;
  localparam int DIV_W         = 8;
  localparam int DEF_CLK_DIV   = 4;
  localparam int DEF_NSS_SETUP = 2;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    NEXT,
    HOLD
  } state_t;

endpackage

// File: rtl/spi_st_master_if.sv
// spi_st_master_if: Avalon-ST sink (bytes to send) and source (bytes received).
// Modports: master = stream producer/consumer side, slave = the SPI master block.
interface spi_st_master_if;
  import spi_st_master_pkg::*;

  logic [SPI_BYTE_BITS-1:0] stsinkdata;
  logic                     stsinkvalid;
  logic                     stsinkready;
  logic [SPI_BYTE_BITS-1:0] stsourcedata;
  logic                     stsourcevalid;
  logic                     stsourceready;

  modport master (
    output stsinkdata,
    output stsinkvalid,
    input  stsinkready,
    input  stsourcedata,
    input  stsourcevalid,
    output stsourceready
  );

  modport slave (
    input  stsinkdata,
    input  stsinkvalid,
    output stsinkready,
    output stsourcedata,
    output stsourcevalid,
    input  stsourceready
  );

endinterface

// File: rtl/spi_st_master_clk_gen.sv
// spi_clk_gen: sclk divider; sclk toggles every CLK_DIV clk cycles while run=1.
// Ports: clk, nreset, run in; sclk, rise, fall out (strobes precede the edge).
module spi_clk_gen
  import spi_st_master_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic clk,
  input  logic nreset,
  input  logic run,
  output logic sclk,
  output logic rise,
  output logic fall
);

  logic [DIV_W-1:0] div_cnt;
  logic             tick;

  assign tick = (div_cnt == DIV_W'(CLK_DIV - 1));
  assign rise = run && tick && !sclk;
  assign fall = run && tick && sclk;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      div_cnt <= '0;
      sclk    <= 1'b0;
    end else if (!run) begin
      div_cnt <= '0;
      sclk    <= 1'b0;
    end else if (tick) begin
      div_cnt <= '0;
      sclk    <= ~sclk;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/spi_st_master.sv
// spi_st_master: SPI mode-0 master moving Avalon-ST bytes over SPI, bursts keep nss low.
// Ports: clk, nreset, st (sink/source), sclk, mosi, nss, miso, busy. RX path: SPI_ST_MASTER_RX_EN.
module spi_st_master
  import spi_st_master_pkg::*;
#(
  parameter int CLK_DIV   = DEF_CLK_DIV,
  parameter int NSS_SETUP = DEF_NSS_SETUP
) (
  input  logic           clk,
  input  logic           nreset,
  spi_st_master_if.slave st,
  output logic           sclk,
  output logic           mosi,
  output logic           nss,
  input  logic           miso,
  output logic           busy
);

  localparam logic [7:0] CNT_LAST = 8'(NSS_SETUP - 1);
  localparam logic [2:0] BIT_LAST = 3'(SPI_BYTE_BITS - 1);

  state_t state, state_nx;

  logic [7:0]               cnt;
  logic [2:0]               bit_cnt;
  logic [SPI_BYTE_BITS-1:0] tx_sh;
  logic                     rdy_en;
  logic                     sink_ready;
  logic                     sink_beat;
  logic                     rise, fall;
  logic                     last_fall;
  logic                     cnt_done;
  logic                     stall;

  spi_clk_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_clk_gen (
    .clk   (clk),
    .nreset(nreset),
    .run   (state == SHIFT),
    .sclk  (sclk),
    .rise  (rise),
    .fall  (fall)
  );

  assign sink_beat = st.stsinkvalid && sink_ready;
  assign last_fall = fall && (bit_cnt == BIT_LAST);
  assign cnt_done  = (cnt >= CNT_LAST);
  assign busy      = (state != IDLE);
  assign st.stsinkready = sink_ready;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) state <= IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (sink_beat) state_nx = SETUP;
      SETUP: if (cnt_done) state_nx = SHIFT;
      SHIFT: if (last_fall) state_nx = NEXT;
      NEXT:  if (!stall) state_nx = sink_beat ? SHIFT : HOLD;
      HOLD:  if (cnt_done) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    nss        = 1'b0;
    sink_ready = 1'b0;
    unique case (state)
      IDLE: begin
        nss        = 1'b1;
        sink_ready = rdy_en;
      end
      NEXT:    sink_ready = rdy_en && !stall;
      default: ;
    endcase
  end

  // ready stays low until the first edge after reset release
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) rdy_en <= 1'b0;
    else         rdy_en <= 1'b1;
  end

  // The NEXT cycle counts toward the trailing nss hold, so HOLD
  // starts at 1 and nss rises NSS_SETUP cycles after the last edge.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      cnt <= '0;
    end else if (state_nx != state) begin
      cnt <= (state_nx == HOLD) ? 8'd1 : 8'd0;
    end else if (state == SETUP || state == HOLD) begin
      cnt <= cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      tx_sh   <= '0;
      mosi    <= 1'b0;
      bit_cnt <= '0;
    end else if (sink_beat) begin
      tx_sh   <= st.stsinkdata;
      mosi    <= st.stsinkdata[SPI_BYTE_BITS-1];
      bit_cnt <= '0;
    end else if (fall) begin
      tx_sh   <= {tx_sh[SPI_BYTE_BITS-2:0], 1'b0};
      mosi    <= tx_sh[SPI_BYTE_BITS-2];
      bit_cnt <= bit_cnt + 3'd1;
    end
  end

`ifdef SPI_ST_MASTER_RX_EN
  logic [SPI_BYTE_BITS-1:0] rx_sh;
  logic [SPI_BYTE_BITS-1:0] src_data;
  logic                     src_valid;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      rx_sh     <= '0;
      src_data  <= '0;
      src_valid <= 1'b0;
    end else begin
      if (rise) rx_sh <= {rx_sh[SPI_BYTE_BITS-2:0], miso};
      if (last_fall) begin
        src_data  <= rx_sh;
        src_valid <= 1'b1;
      end else if (src_valid && st.stsourceready) begin
        src_valid <= 1'b0;
      end
    end
  end

  assign st.stsourcedata  = src_data;
  assign st.stsourcevalid = src_valid;
  assign stall = src_valid && !st.stsourceready;
`else
  logic unused_rx;

  assign unused_rx = miso ^ rise ^ st.stsourceready;
  assign st.stsourcedata  = '0;
  assign st.stsourcevalid = 1'b0;
  assign stall = 1'b0;
`endif

endmodule

// File: tb/tb_spi_st_master.sv
// tb_spi_st_master: directed + random bench for spi_st_master with an SPI slave model.
// Checks mosi bytes, nss framing, burst/stall/reset behaviour and RX bytes when enabled.
module tb_spi_st_master;

  localparam int D        = 4;
  localparam int NS       = 2;
  localparam int BYTE_CYC = 16 * D;
  localparam int LIM      = 20000;

  logic clk = 1'b0;
  logic nreset;
  logic sclk, mosi, nss, busy;
  logic miso = 1'b0;

  spi_st_master_if sif ();

  spi_st_master #(
    .CLK_DIV  (D),
    .NSS_SETUP(NS)
  ) dut (
    .clk   (clk),
    .nreset(nreset),
    .st    (sif),
    .sclk  (sclk),
    .mosi  (mosi),
    .nss   (nss),
    .miso  (miso),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic       mosi_bits[$];
  logic [7:0] rx_q[$];
  logic [7:0] slv_mem[$];
  int slv_rise = 0;
  int slv_base = 0;
  int nss_low  = 0;
  int nss_rise = 0;
  int src_seen = 0;

  int mo_base, rx_base, low_base, rise_base, seen_base;

  // slave: returns slv_mem bytes MSB-first, changes miso on sclk fall
  function automatic logic slv_out(input int k);
    logic [7:0] v;
    int idx;
    idx = k / 8;
    v = (idx < slv_mem.size()) ? slv_mem[idx] : 8'h00;
    return v[7 - (k % 8)];
  endfunction

  always @(posedge sclk) begin
    if (nreset && !nss) begin
      slv_rise++;
      mosi_bits.push_back(mosi);
    end
  end

  always @(negedge sclk or negedge nss)
    miso = slv_out(slv_rise - slv_base);

  always @(posedge nss) nss_rise++;

  always @(negedge clk) begin
    if (nreset && !nss) nss_low++;
    if (sif.stsourcevalid && sif.stsourceready)
      rx_q.push_back(sif.stsourcedata);
    if (sif.stsourcevalid) src_seen++;
  end

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    slv_base  = slv_rise;
    mo_base   = mosi_bits.size();
    rx_base   = rx_q.size();
    low_base  = nss_low;
    rise_base = nss_rise;
    seen_base = src_seen;
  endtask

  function automatic logic [7:0] mosi_byte(input int k);
    logic [7:0] v = '0;
    for (int i = 0; i < 8; i++)
      v = {v[6:0], mosi_bits[mo_base + 8*k + i]};
    return v;
  endfunction

  // nss low span: setup + bytes + one handoff per extra byte + hold
  function automatic int exp_nss(input int n);
    return 2*NS + n*BYTE_CYC + (n - 1);
  endfunction

  task automatic push(input logic [7:0] b);
    int n = 0;
    sif.stsinkdata  = b;
    sif.stsinkvalid = 1'b1;
    while (!sif.stsinkready && n < LIM) begin
      @(negedge clk);
      n++;
    end
    check("push_wait", n < LIM, 1);
    @(posedge clk);
    #1 sif.stsinkvalid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    @(negedge clk);
    while ((busy || !nss) && n < LIM) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_idle"}, busy, 0);
    check({tag, "_rdy"}, sif.stsinkready, 1);
  endtask

  task automatic check_tx(input string tag,
                          input int k,
                          input logic [7:0] exp);
    check($sformatf("%s_tx%0d", tag, k), mosi_byte(k), exp);
  endtask

  task automatic check_rx(input string tag, input int cnt);
`ifdef SPI_ST_MASTER_RX_EN
    check({tag, "_rxn"}, rx_q.size() - rx_base, cnt);
    for (int i = 0; i < cnt; i++)
      check($sformatf("%s_rx%0d", tag, i),
            rx_q[rx_base + i], slv_mem[i]);
`else
    check({tag, "_rxn"}, rx_q.size() - rx_base, 0);
    check({tag, "_vld0"}, src_seen - seen_base, 0);
`endif
  endtask

  initial begin
    int n;
    int bad;
    logic [7:0] b, r;

    sif.stsinkdata    = '0;
    sif.stsinkvalid   = 1'b0;
    sif.stsourceready = 1'b1;
    nreset = 1'b1;
    #1 nreset = 1'b0;
    #2;
    check("rst_nss", nss, 1);
    check("rst_sclk", sclk, 0);
    check("rst_mosi", mosi, 0);
    check("rst_rdy", sif.stsinkready, 0);
    check("rst_vld", sif.stsourcevalid, 0);
    check("rst_data", sif.stsourcedata, 0);
    check("rst_busy", busy, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    nreset = 1'b1;
    #1 check("rel_rdy_lo", sif.stsinkready, 0);
    @(posedge clk);
    #1 check("rel_rdy_hi", sif.stsinkready, 1);

    // single byte
    clr();
    slv_mem = {8'h3C};
    push(8'hA5);
    @(negedge clk);
    check("t1_busy", busy, 1);
    check("t1_nss_lo", nss, 0);
    wait_idle("t1");
    check("t1_bits", mosi_bits.size() - mo_base, 8);
    check_tx("t1", 0, 8'hA5);
    check("t1_nss", nss_low - low_base, exp_nss(1));
    check_rx("t1", 1);

    // burst of three
    clr();
    slv_mem = {8'($urandom), 8'($urandom), 8'($urandom)};
    push(8'h01);
    push(8'h02);
    push(8'h03);
    wait_idle("t2");
    check("t2_bits", mosi_bits.size() - mo_base, 24);
    check_tx("t2", 0, 8'h01);
    check_tx("t2", 1, 8'h02);
    check_tx("t2", 2, 8'h03);
    check("t2_nss", nss_low - low_base, exp_nss(3));
    check("t2_rise", nss_rise - rise_base, 1);
    check_rx("t2", 3);

    // source backpressure across a two-byte burst
    clr();
    b = 8'($urandom);
    r = 8'($urandom);
    slv_mem = {8'($urandom), 8'($urandom)};
    sif.stsourceready = 1'b0;
`ifdef SPI_ST_MASTER_RX_EN
    push(b);
    sif.stsinkdata  = r;
    sif.stsinkvalid = 1'b1;
    n = 0;
    while (!sif.stsourcevalid && n < LIM) begin
      @(negedge clk);
      n++;
    end
    check("bp_vld", sif.stsourcevalid, 1);
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (sclk || nss || sif.stsinkready || !sif.stsourcevalid)
        bad++;
    end
    check("bp_stall", bad, 0);
    check("bp_held", sif.stsourcedata, slv_mem[0]);
    check("bp_bits1", mosi_bits.size() - mo_base, 8);
    @(posedge clk);
    #1 sif.stsourceready = 1'b1;
    @(negedge clk);
    n = 0;
    while (!sif.stsinkready && n < LIM) begin
      @(negedge clk);
      n++;
    end
    check("bp_beat", n < LIM, 1);
    @(posedge clk);
    #1 sif.stsinkvalid = 1'b0;
    wait_idle("t3");
`else
    push(b);
    push(r);
    wait_idle("t3");
    check("t3_nss", nss_low - low_base, exp_nss(2));
`endif
    sif.stsourceready = 1'b1;
    check("t3_bits", mosi_bits.size() - mo_base, 16);
    check_tx("t3", 0, b);
    check_tx("t3", 1, r);
    check("t3_rise", nss_rise - rise_base, 1);
    check_rx("t3", 2);

    // reset in the middle of a byte
    clr();
    slv_mem = {8'h5A};
    push(8'hFF);
    n = 0;
    while (mosi_bits.size() - mo_base < 3 && n < LIM) begin
      @(negedge clk);
      n++;
    end
    check("rm_bits3", mosi_bits.size() - mo_base, 3);
    #2 nreset = 1'b0;
    #1;
    check("rm_nss", nss, 1);
    check("rm_sclk", sclk, 0);
    check("rm_vld", sif.stsourcevalid, 0);
    check("rm_busy", busy, 0);
    check("rm_rdy", sif.stsinkready, 0);
    @(negedge clk);
    nreset = 1'b1;
    @(posedge clk);
    #1;
    clr();
    slv_mem = {8'($urandom)};
    push(8'h81);
    wait_idle("t4");
    check("t4_bits", mosi_bits.size() - mo_base, 8);
    check_tx("t4", 0, 8'h81);
    check("t4_nss", nss_low - low_base, exp_nss(1));
    check_rx("t4", 1);

    // random single bytes
    for (int k = 0; k < 3; k++) begin
      clr();
      b = 8'($urandom);
      slv_mem = {8'($urandom)};
      push(b);
      wait_idle("t5");
      check_tx("t5", 0, b);
      check("t5_nss", nss_low - low_base, exp_nss(1));
      check_rx("t5", 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spi_st_master.md
SPI_ST_MASTER -- requirements
Module: spi_st_master

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4: SCLK half-period in clk cycles, legal range 2..255.
REQ-002 SHALL have parameter NSS_SETUP, default 2: clk cycles from nss falling to first SCLK edge, and from last SCLK edge to nss rising.
REQ-003 SHALL have port clk, input, 1 bit: single system clock.
REQ-004 SHALL have port nreset, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have ports stsinkdata (input, 8), stsinkvalid (input, 1) and stsinkready (output, 1): Avalon-ST sink carrying bytes to transmit.
REQ-006 SHALL have ports stsourcedata (output, 8), stsourcevalid (output, 1) and stsourceready (input, 1): Avalon-ST source carrying received bytes.
REQ-007 SHALL have ports sclk, mosi and nss (outputs, 1 each) and miso (input, 1): SPI bus.
REQ-008 SHALL have port busy, output, 1 bit: high whenever the FSM is not in IDLE.

Function
REQ-009 SHALL operate SPI mode 0: sclk idles low; mosi is driven MSB-first and is stable before each rising edge; miso is sampled on each rising sclk edge.
REQ-010 SHALL implement FSM states IDLE, SETUP, SHIFT, NEXT and HOLD.
REQ-011 IDLE: nss=1, sclk=0, stsinkready=1; a sink beat (valid&ready) loads the TX shift register and enters SETUP.
REQ-012 SETUP: nss=0 for NSS_SETUP cycles, then enter SHIFT with mosi = bit7.
REQ-013 SHIFT: 8 sclk periods of 2*CLK_DIV clk cycles each; a byte occupies 16*CLK_DIV cycles; mosi updates on the falling edge.
REQ-014 After the 8th falling edge, the RX byte SHALL be presented on stsourcedata with stsourcevalid=1 in the next cycle; stsourcevalid holds until stsourceready=1.
REQ-015 NEXT: stsinkready=1 for exactly one cycle, with nss held low; a beat returns to SHIFT with no SETUP (burst); otherwise enter HOLD.
REQ-016 HOLD: nss stays low for NSS_SETUP cycles, then nss=1 and return to IDLE.
REQ-017 SHALL stall in NEXT, with stsinkready=0 and sclk low, while stsourcevalid=1 and stsourceready=0; no RX byte is ever dropped or overwritten.
REQ-018 stsinkready SHALL be 0 in SETUP, SHIFT and HOLD; sink data is ignored unless both valid and ready are high.
REQ-019 A simultaneous source acceptance and NEXT-state sink beat in the same cycle SHALL both take effect.
REQ-020 CLK_DIV counter width SHALL be 8 bits; the bit counter SHALL be 3 bits and wrap 7->0 only at the byte end.

Reset
REQ-021 nreset low SHALL force immediately: state=IDLE, nss=1, sclk=0, mosi=0, stsinkready=0 while in reset, stsourcevalid=0, stsourcedata=0, busy=0, all counters 0.
REQ-022 Reset mid-byte SHALL abort the transfer and discard the partial RX byte; nss rises asynchronously.
REQ-023 stsinkready SHALL go high on the first clk edge after nreset deasserts.

Configuration
REQ-024 Macro SPI_ST_MASTER_RX_EN SHALL gate the receive path.
REQ-025 With the macro defined: full behaviour per REQ-014 and REQ-017.
REQ-026 Without the macro: no RX shift register is built; stsourcevalid=0 and stsourcedata=0 constantly; miso is unused; REQ-017 never stalls.

Structure
REQ-027 The shared package SHALL hold the FSM state enum, the SPI_BYTE_BITS=8 constant and the default CLK_DIV/NSS_SETUP values.
REQ-028 The sclk generator (divide counter plus rise/fall strobes) SHALL be a sub-module named spi_clk_gen.

Verification
REQ-029 Single byte: CLK_DIV=4, send 0xA5, miso slave returns 0x3C -> mosi bits 1,0,1,0,0,1,0,1; stsourcedata=0x3C; nss low for 2+64+2 cycles.
REQ-030 Burst: 0x01,0x02,0x03 offered back-to-back -> nss stays low across all 3 bytes, no SETUP between bytes, 3 RX beats in order.
REQ-031 Backpressure: stsourceready=0 for 100 cycles after byte 1 of 2 -> sclk idle and nss low throughout; byte 2 starts after acceptance; both RX bytes intact.
REQ-032 Reset mid-byte: nreset low after bit 3 of 0xFF -> nss=1 and sclk=0 immediately, stsourcevalid=0; next transfer of 0x81 is correct.
REQ-033 Build without SPI_ST_MASTER_RX_EN: 2-byte burst with stsourceready=0 -> no stall, stsourcevalid stays 0, mosi correct.
